axis_wconv_v2: RTL and testbench
================================

AXIS_WCONV_V2 -- requirements
Module: axis_wconv_v2

Interface
REQ-001 SHALL have parameter B, default 16, sample width in bits.
REQ-002 SHALL have parameter NIN, default 12, samples per input beat (>=1).
REQ-003 SHALL have parameter NOUT, default 16, samples per output beat (>=1).
REQ-004 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port areset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_axis_tvalid  input  1  input beat valid.
REQ-007 SHALL have port s_axis_tready  output  1  input beat accepted when high with tvalid.
REQ-008 SHALL have port s_axis_tdata  input  NIN*B  sample i in bits [i*B +: B].
REQ-009 SHALL have port s_axis_tlast  input  1  last beat of packet; triggers flush.
REQ-010 SHALL have port m_axis_tvalid  output  1  output beat valid.
REQ-011 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-012 SHALL have port m_axis_tdata  output  NOUT*B  sample j in bits [j*B +: B].
REQ-013 SHALL have port m_axis_tlast  output  1  final (possibly zero-padded) beat of packet.

Function
REQ-014 SHALL hold samples in buffer of depth D = NIN+NOUT, occupancy counter cnt (0..D), buffer index 0 = oldest sample.
REQ-015 SHALL preserve sample order: input lane 0 first, output lane 0 = oldest buffered sample.
REQ-016 SHALL drive s_axis_tready = (D-cnt >= NIN) && !flush, from registered state only.
REQ-017 SHALL drive m_axis_tvalid = (cnt >= NOUT) || (flush && cnt > 0), from registered state only.
REQ-018 SHALL present buffer[0..NOUT-1] on m_axis_tdata; lanes at index >= cnt SHALL be zero.
REQ-019 SHALL pop min(NOUT,cnt) samples on m_axis handshake; remaining samples shift down.
REQ-020 SHALL append NIN samples at index cnt (or cnt-popped if same-cycle pop) on s_axis handshake.
REQ-021 SHALL handle simultaneous push and pop in one cycle: cnt_next = cnt + NIN - popped.
REQ-022 SHALL set flush on accepted beat with s_axis_tlast=1; no input accepted while flush=1.
REQ-023 SHALL assert m_axis_tlast = flush && cnt <= NOUT; flush clears on that beat's handshake.
REQ-024 SHALL give latency of 1 cycle: sample accepted at edge t is visible on m_axis after edge t.
REQ-025 SHALL hold m_axis_tdata/tvalid/tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-026 SHALL never overflow or drop samples; full condition throttles s_axis_tready only.

Reset
REQ-027 SHALL, on areset=1 at a clock edge, clear cnt, flush and buffer contents.
REQ-028 SHALL hold s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0 while areset=1.
REQ-029 SHALL discard partial data on reset mid-packet; first post-reset beat starts at buffer index 0.

Structure
REQ-030 SHALL place D, counter width $clog2(D+1) and parameter-check functions in package axis_wconv_pkg.
REQ-031 SHALL implement buffer/shift/append datapath in one sub-module, wconv_sbuf; control (cnt, flush, handshakes) stays in top.
REQ-032 SHALL flag NIN<1 or NOUT<1 as an elaboration error.

Verification
REQ-033 SHALL test defaults, 4 beats ramp 0..47, m_tready=1 -> 3 beats 0..15, 16..31, 32..47, tlast=0.
REQ-034 SHALL test m_tready=0, continuous valid ramp -> 2 beats accepted (cnt=24), s_tready=0, m_tdata holds 0..15.
REQ-035 SHALL test one beat 0..11 with tlast -> one beat, lanes 0..11 = 0..11, lanes 12..15 = 0, tlast=1.
REQ-036 SHALL test 5 beats 0..59, tlast on 5th -> 0..15, 16..31, 32..47, then 48..59 + 4 zero lanes with tlast=1; s_tready low until flushed.
REQ-037 SHALL test areset pulsed after 1 beat (cnt=12) -> m_tvalid=0; next ramp from 100 emerges starting at 100.
REQ-038 SHALL test NIN=16, NOUT=12, 3 beats 0..47 -> 4 beats 0..11, 12..23, 24..35, 36..47 under random m_tready.

Source files
------------

// File: rtl/axis_wconv_pkg.sv
// Shared sizing and parameter-legality helpers for the AXI-Stream sample width converter.
package axis_wconv_pkg;

    function automatic int wconv_depth(input int nin, input int nout);
        return nin + nout;
    endfunction

    function automatic int wconv_cnt_w(input int nin, input int nout);
        return $clog2(nin + nout + 1);
    endfunction

    function automatic bit wconv_params_ok(input int nin, input int nout);
        return (nin >= 1) && (nout >= 1);
    endfunction

endpackage

// File: rtl/wconv_sbuf.sv
// Sample shift buffer: pops the oldest pop_cnt samples and appends a beat behind the survivors.
// Entries at or beyond the occupancy are always zero, so the head window is already zero-padded.
module wconv_sbuf
    import axis_wconv_pkg::*;
#(
    parameter int B    = 16,
    parameter int NIN  = 12,
    parameter int NOUT = 16,
    parameter int D    = NIN + NOUT,
    parameter int CW   = $clog2(D + 1)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              push,
    input  logic [CW-1:0]     cnt,
    input  logic [CW-1:0]     pop_cnt,
    input  logic [NIN*B-1:0]  in_dat,
    output logic [NOUT*B-1:0] head
);

    logic [D*B-1:0] mem;
    logic [D*B-1:0] mem_nxt;
    int             base;

    always_comb begin
        mem_nxt = '0;
        base    = int'(cnt) - int'(pop_cnt);
        for (int i = 0; i < D; i++) begin
            if (i + int'(pop_cnt) < D) begin
                mem_nxt[i*B +: B] = mem[(i + int'(pop_cnt))*B +: B];
            end
            // New lanes land directly behind what survives this cycle's pop.
            if (push && (i >= base) && (i < base + NIN)) begin
                mem_nxt[i*B +: B] = in_dat[(i - base)*B +: B];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            mem <= '0;
        end else begin
            mem <= mem_nxt;
        end
    end

    assign head = mem[NOUT*B-1:0];

endmodule

// File: rtl/axis_wconv_v2.sv
// AXI-Stream sample-count converter NIN->NOUT lanes, 1-cycle latency; tlast flushes a zero-padded final beat.
// s_axis_tready drops when a full beat no longer fits or while flushing; outputs hold under m_axis stall.
module axis_wconv_v2
    import axis_wconv_pkg::*;
#(
    parameter int B    = 16,
    parameter int NIN  = 12,
    parameter int NOUT = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [NIN*B-1:0]  s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [NOUT*B-1:0] m_axis_tdata,
    output logic              m_axis_tlast
);

    localparam int D  = wconv_depth(NIN, NOUT);
    localparam int CW = wconv_cnt_w(NIN, NOUT);

    if (!wconv_params_ok(NIN, NOUT)) begin : g_bad_params
        $error("axis_wconv_v2: NIN and NOUT must both be at least 1");
    end

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     pop_cnt;
    logic              flush;
    logic              s_rdy;
    logic              m_vld;
    logic              m_lst;
    logic              s_hs;
    logic              m_hs;
    logic [NOUT*B-1:0] head;

    assign s_rdy = (cnt <= CW'(D - NIN)) && !flush;
    assign m_vld = (cnt >= CW'(NOUT)) || (flush && (cnt != '0));
    assign m_lst = flush && (cnt <= CW'(NOUT));

    // Outputs are forced quiet while reset is held, even before the first reset edge.
    assign s_axis_tready = s_rdy && !areset;
    assign m_axis_tvalid = m_vld && !areset;
    assign m_axis_tlast  = m_lst && !areset;
    assign m_axis_tdata  = areset ? '0 : head;

    assign s_hs    = s_axis_tvalid && s_axis_tready;
    assign m_hs    = m_axis_tvalid && m_axis_tready;
    assign pop_cnt = !m_hs ? '0 : ((cnt >= CW'(NOUT)) ? CW'(NOUT) : cnt);

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt   <= '0;
            flush <= 1'b0;
        end else begin
            cnt <= cnt + (s_hs ? CW'(NIN) : '0) - pop_cnt;
            if (m_hs && m_axis_tlast) begin
                flush <= 1'b0;
            end else if (s_hs && s_axis_tlast) begin
                flush <= 1'b1;
            end
        end
    end

    wconv_sbuf #(
        .B    (B),
        .NIN  (NIN),
        .NOUT (NOUT),
        .D    (D),
        .CW   (CW)
    ) u_sbuf (
        .aclk    (aclk),
        .areset  (areset),
        .push    (s_hs),
        .cnt     (cnt),
        .pop_cnt (pop_cnt),
        .in_dat  (s_axis_tdata),
        .head    (head)
    );

endmodule

// File: tb/tb_axis_wconv_v2.sv
// Directed bench for axis_wconv_v2: default 12->16 instance plus a 16->12 instance under random m_axis_tready.
module tb_axis_wconv_v2;

    localparam int B = 16;
    typedef logic [255:0] wide_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic           s_tvalid1 = 1'b0, s_tlast1 = 1'b0, m_tready1 = 1'b0;
    logic           s_tready1, m_tvalid1, m_tlast1;
    logic [12*B-1:0] s_tdata1 = '0;
    logic [16*B-1:0] m_tdata1;

    logic           s_tvalid2 = 1'b0, s_tlast2 = 1'b0, m_tready2 = 1'b0;
    logic           s_tready2, m_tvalid2, m_tlast2;
    logic [16*B-1:0] s_tdata2 = '0;
    logic [12*B-1:0] m_tdata2;

    axis_wconv_v2 dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_tvalid1), .s_axis_tready(s_tready1),
        .s_axis_tdata(s_tdata1), .s_axis_tlast(s_tlast1),
        .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready1),
        .m_axis_tdata(m_tdata1), .m_axis_tlast(m_tlast1)
    );

    axis_wconv_v2 #(.B(16), .NIN(16), .NOUT(12)) dut2 (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_tvalid2), .s_axis_tready(s_tready2),
        .s_axis_tdata(s_tdata2), .s_axis_tlast(s_tlast2),
        .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready2),
        .m_axis_tdata(m_tdata2), .m_axis_tlast(m_tlast2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: a packet is a ramp of samples cut into NOUT-sample beats; the tail of a
    // tlast packet becomes one zero-padded beat marked last.
    wide_t exp1_q[$];
    bit    expl1_q[$];
    wide_t exp2_q[$];
    bit    expl2_q[$];

    task automatic push_exp(input int which, input wide_t w, input bit l);
        if (which == 1) begin
            exp1_q.push_back(w);
            expl1_q.push_back(l);
        end else begin
            exp2_q.push_back(w);
            expl2_q.push_back(l);
        end
    endtask

    task automatic build(input int which, input int start, input int nbeats, input bit last);
        int nin = (which == 1) ? 12 : 16;
        int nout = (which == 1) ? 16 : 12;
        int total = nbeats * nin;
        int pos = 0;
        wide_t w;
        while ((total - pos > nout) || (!last && (total - pos >= nout))) begin
            w = '0;
            for (int j = 0; j < nout; j++) w[j*B +: B] = 16'(start + pos + j);
            push_exp(which, w, 1'b0);
            pos += nout;
        end
        if (last && (pos < total)) begin
            w = '0;
            for (int j = 0; j < total - pos; j++) w[j*B +: B] = 16'(start + pos + j);
            push_exp(which, w, 1'b1);
        end
    endtask

    wide_t last_dat1, last_dat2, prev_dat1, prev_dat2;
    bit    last_l1, last_l2, prev_l1, prev_l2;
    bit    stall1 = 0, stall2 = 0;
    int    n_beats1 = 0, n_beats2 = 0;

    always @(negedge aclk) begin
        if (areset) begin
            stall1 = 0;
        end else begin
            if (stall1) begin
                chk("hold_dat1", wide_t'(m_tdata1), prev_dat1);
                chk("hold_vld1", wide_t'(m_tvalid1), wide_t'(1));
                chk("hold_last1", wide_t'(m_tlast1), wide_t'(prev_l1));
            end
            if (m_tvalid1 && m_tready1) begin
                n_beats1++;
                last_dat1 = wide_t'(m_tdata1);
                last_l1 = m_tlast1;
                if (exp1_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat1: got %0h, expected no beat", m_tdata1);
                end else begin
                    chk("beat_dat1", wide_t'(m_tdata1), exp1_q.pop_front());
                    chk("beat_last1", wide_t'(m_tlast1), wide_t'(expl1_q.pop_front()));
                end
            end
            stall1 = m_tvalid1 && !m_tready1;
            prev_dat1 = wide_t'(m_tdata1);
            prev_l1 = m_tlast1;
        end
    end

    always @(negedge aclk) begin
        if (areset) begin
            stall2 = 0;
        end else begin
            if (stall2) begin
                chk("hold_dat2", wide_t'(m_tdata2), prev_dat2);
                chk("hold_vld2", wide_t'(m_tvalid2), wide_t'(1));
                chk("hold_last2", wide_t'(m_tlast2), wide_t'(prev_l2));
            end
            if (m_tvalid2 && m_tready2) begin
                n_beats2++;
                last_dat2 = wide_t'(m_tdata2);
                last_l2 = m_tlast2;
                if (exp2_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat2: got %0h, expected no beat", m_tdata2);
                end else begin
                    chk("beat_dat2", wide_t'(m_tdata2), exp2_q.pop_front());
                    chk("beat_last2", wide_t'(m_tlast2), wide_t'(expl2_q.pop_front()));
                end
            end
            stall2 = m_tvalid2 && !m_tready2;
            prev_dat2 = wide_t'(m_tdata2);
            prev_l2 = m_tlast2;
        end
    end

    bit rnd_rdy2 = 0;
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_tready2 = rnd_rdy2 ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic send1(input int base, input bit last);
        int t = 0;
        s_tvalid1 = 1'b1;
        s_tlast1 = last;
        for (int i = 0; i < 12; i++) s_tdata1[i*B +: B] = 16'(base + i);
        @(negedge aclk);
        while (!s_tready1 && t < 200) begin
            @(negedge aclk);
            t++;
        end
        chk("accept_timeout1", wide_t'(t < 200), wide_t'(1));
        @(posedge aclk);
        #1;
        s_tvalid1 = 1'b0;
        s_tlast1 = 1'b0;
    endtask

    task automatic send2(input int base);
        int t = 0;
        s_tvalid2 = 1'b1;
        for (int i = 0; i < 16; i++) s_tdata2[i*B +: B] = 16'(base + i);
        @(negedge aclk);
        while (!s_tready2 && t < 200) begin
            @(negedge aclk);
            t++;
        end
        chk("accept_timeout2", wide_t'(t < 200), wide_t'(1));
        @(posedge aclk);
        #1;
        s_tvalid2 = 1'b0;
    endtask

    task automatic drain(input int which);
        int t = 0;
        while (((which == 1) ? exp1_q.size() : exp2_q.size()) != 0 && t < 500) begin
            @(negedge aclk);
            t++;
        end
        chk("drain_timeout", wide_t'(t < 500), wide_t'(1));
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    initial begin
        wide_t ramp16;
        int nb;
        ramp16 = '0;
        for (int j = 0; j < 16; j++) ramp16[j*B +: B] = 16'(j);

        // Outputs quiet while reset is held.
        @(negedge aclk);
        chk("rst_s_tready", wide_t'(s_tready1), '0);
        chk("rst_m_tvalid", wide_t'(m_tvalid1), '0);
        chk("rst_m_tlast", wide_t'(m_tlast1), '0);
        chk("rst_m_tdata", wide_t'(m_tdata1), '0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_s_tready", wide_t'(s_tready1), wide_t'(1));
        chk("post_rst_m_tvalid", wide_t'(m_tvalid1), '0);
        @(posedge aclk);
        #1;

        // Four 12-sample beats regroup into three 16-sample beats.
        m_tready1 = 1'b1;
        nb = n_beats1;
        build(1, 0, 4, 1'b0);
        for (int k = 0; k < 4; k++) send1(k * 12, 1'b0);
        drain(1);
        chk("ramp_beats", wide_t'(n_beats1 - nb), wide_t'(3));
        chk("ramp_lane15", wide_t'(last_dat1[15*B +: B]), wide_t'(47));
        chk("ramp_tlast", wide_t'(last_l1), '0);
        pulse_reset();

        // Downstream stalled: two beats fit, then input is throttled and the head holds.
        m_tready1 = 1'b0;
        send1(0, 1'b0);
        send1(12, 1'b0);
        s_tvalid1 = 1'b1;
        for (int i = 0; i < 12; i++) s_tdata1[i*B +: B] = 16'(24 + i);
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            chk("full_s_tready", wide_t'(s_tready1), '0);
            chk("full_m_tvalid", wide_t'(m_tvalid1), wide_t'(1));
            chk("full_m_tdata", wide_t'(m_tdata1), ramp16);
        end
        @(posedge aclk);
        #1;
        s_tvalid1 = 1'b0;
        pulse_reset();

        // Single-beat packet flushes as one padded last beat.
        m_tready1 = 1'b1;
        build(1, 0, 1, 1'b1);
        send1(0, 1'b1);
        drain(1);
        chk("short_lane11", wide_t'(last_dat1[11*B +: B]), wide_t'(11));
        chk("short_lane12", wide_t'(last_dat1[12*B +: B]), '0);
        chk("short_tlast", wide_t'(last_l1), wide_t'(1));

        // Five-beat packet: three full beats, then 48..59 padded; no input accepted mid-flush.
        build(1, 0, 5, 1'b1);
        for (int k = 0; k < 4; k++) send1(k * 12, 1'b0);
        send1(48, 1'b1);
        m_tready1 = 1'b0;
        s_tvalid1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk("flush_s_tready", wide_t'(s_tready1), '0);
            chk("flush_m_tvalid", wide_t'(m_tvalid1), wide_t'(1));
        end
        @(posedge aclk);
        #1;
        s_tvalid1 = 1'b0;
        m_tready1 = 1'b1;
        drain(1);
        @(negedge aclk);
        chk("flushed_s_tready", wide_t'(s_tready1), wide_t'(1));
        chk("tail_lane0", wide_t'(last_dat1[0 +: B]), wide_t'(48));
        chk("tail_lane11", wide_t'(last_dat1[11*B +: B]), wide_t'(59));
        chk("tail_lane12", wide_t'(last_dat1[12*B +: B]), '0);
        chk("tail_tlast", wide_t'(last_l1), wide_t'(1));
        @(posedge aclk);
        #1;

        // Reset mid-packet discards the partial beat.
        send1(0, 1'b0);
        pulse_reset();
        @(negedge aclk);
        chk("mid_rst_m_tvalid", wide_t'(m_tvalid1), '0);
        chk("mid_rst_s_tready", wide_t'(s_tready1), wide_t'(1));
        @(posedge aclk);
        #1;
        build(1, 100, 4, 1'b0);
        for (int k = 0; k < 4; k++) send1(100 + k * 12, 1'b0);
        drain(1);
        chk("restart_lane0", wide_t'(last_dat1[0 +: B]), wide_t'(132));

        // Widening-to-narrowing instance under random downstream ready.
        rnd_rdy2 = 1;
        build(2, 0, 3, 1'b0);
        for (int k = 0; k < 3; k++) send2(k * 16);
        drain(2);
        chk("n2_beats", wide_t'(n_beats2), wide_t'(4));
        chk("n2_lane0", wide_t'(last_dat2[0 +: B]), wide_t'(36));
        chk("n2_lane11", wide_t'(last_dat2[11*B +: B]), wide_t'(47));
        chk("n2_tlast", wide_t'(last_l2), '0);
        rnd_rdy2 = 0;

        chk("exp1_empty", wide_t'(exp1_q.size()), '0);
        chk("exp2_empty", wide_t'(exp2_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
